// File: rtl/seg7_scan_decoder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : seg7_scan_decoder
// Description : Receive-side decoder for a time-multiplexed 7-segment bus.
//               Synchronizes the segment pattern and one-hot digit select,
//               waits for a stable run, then decodes the pattern back to a
//               hex nibble and stores it in a per-digit register file.
// Ports       : clk, rst_n       - clock, async active-low reset
//               seg_in[6:0]      - segment pattern, bit6=a .. bit0=g
//               dig_sel[N-1:0]   - one-hot digit select
//               hex_out          - decoded nibbles, digit i at [4i+3:4i]
//               digit_valid      - digit i holds a valid decode
//               upd_pulse        - strobe: legal digit accepted
//               err_pulse        - strobe: illegal digit accepted
//               upd_idx          - index of the accepted digit
//               frame_done       - strobe: all digits accepted since last one
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_decoder #(
    parameter int N_DIGITS      = 4,
    parameter int STABLE_CYCLES = 4,
    localparam int IW           = $clog2(N_DIGITS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            seg_in,
    input  logic [N_DIGITS-1:0]   dig_sel,
    output logic [4*N_DIGITS-1:0] hex_out,
    output logic [N_DIGITS-1:0]   digit_valid,
    output logic                  upd_pulse,
    output logic                  err_pulse,
    output logic [IW-1:0]         upd_idx,
    output logic                  frame_done
);

    localparam int                RW         = $clog2(STABLE_CYCLES + 1);
    localparam logic [RW-1:0]     C_STABLE   = RW'(STABLE_CYCLES);
    localparam logic [RW-1:0]     C_RUN_ONE  = RW'(1);
    localparam logic [N_DIGITS-1:0] C_ALL_SEEN = '1;

    localparam logic [0:0] S_TRACK = 1'b0;
    localparam logic [0:0] S_HOLD  = 1'b1;

    // Returns {legal, nibble}
    function automatic logic [4:0] decode_seg(input logic [6:0] seg);
        case (seg)
            7'h7E: decode_seg = 5'h10;
            7'h30: decode_seg = 5'h11;
            7'h6D: decode_seg = 5'h12;
            7'h79: decode_seg = 5'h13;
            7'h33: decode_seg = 5'h14;
            7'h5B: decode_seg = 5'h15;
            7'h5F: decode_seg = 5'h16;
            7'h70: decode_seg = 5'h17;
            7'h7F: decode_seg = 5'h18;
            7'h7B: decode_seg = 5'h19;
            7'h77: decode_seg = 5'h1A;
            7'h1F: decode_seg = 5'h1B;
            7'h4E: decode_seg = 5'h1C;
            7'h3D: decode_seg = 5'h1D;
            7'h4F: decode_seg = 5'h1E;
            7'h47: decode_seg = 5'h1F;
            default: decode_seg = 5'h00;
        endcase
    endfunction

    logic [6:0]            r_seg_s1, r_seg_s2, r_seg_prev;
    logic [N_DIGITS-1:0]   r_sel_s1, r_sel_s2, r_sel_prev;
    logic [RW-1:0]         r_run;
    logic [0:0]            r_state;
    logic [4*N_DIGITS-1:0] r_hex;
    logic [N_DIGITS-1:0]   r_valid;
    logic [N_DIGITS-1:0]   r_seen;
    logic                  r_upd, r_err, r_frame;
    logic [IW-1:0]         r_idx;

    logic                  w_onehot;
    logic                  w_changed;
    logic [RW-1:0]         w_run;
    logic                  w_ready;
    logic                  w_accept;
    logic [0:0]            w_state_next;
    logic [IW-1:0]         w_idx;
    logic [4:0]            w_dec;
    logic [N_DIGITS-1:0]   w_seen_next;

    // Second-stage sample plus a copy of the previous sample for run detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg_s1   <= '0;
            r_seg_s2   <= '0;
            r_seg_prev <= '0;
            r_sel_s1   <= '0;
            r_sel_s2   <= '0;
            r_sel_prev <= '0;
        end else begin
            r_seg_s1   <= seg_in;
            r_seg_s2   <= r_seg_s1;
            r_seg_prev <= r_seg_s2;
            r_sel_s1   <= dig_sel;
            r_sel_s2   <= r_sel_s1;
            r_sel_prev <= r_sel_s2;
        end
    end

    assign w_onehot    = (r_sel_s2 != '0) && ((r_sel_s2 & (r_sel_s2 - 1'b1)) == '0);
    assign w_changed   = {r_seg_s2, r_sel_s2} != {r_seg_prev, r_sel_prev};
    assign w_dec       = decode_seg(r_seg_s2);
    assign w_seen_next = r_seen | r_sel_s2;

    // Run length of the current sample, including the current cycle
    always_comb begin
        w_run = '0;
        if (!w_onehot)
            w_run = '0;
        else if (w_changed)
            w_run = C_RUN_ONE;
        else if (r_run >= C_STABLE)
            w_run = C_STABLE;
        else
            w_run = r_run + C_RUN_ONE;
    end

    assign w_ready = w_onehot && (w_run == C_STABLE);

    always_comb begin
        w_idx = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (r_sel_s2[i])
                w_idx = IW'(i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run   <= '0;
            r_state <= S_TRACK;
        end else begin
            r_run   <= w_run;
            r_state <= w_state_next;
        end
    end

    // A stable digit is accepted once; HOLD waits for the sample to move.
    // The accept-on-change path in HOLD only matters when STABLE_CYCLES=1.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            S_TRACK: begin
                if (w_ready) begin
                    w_accept     = 1'b1;
                    w_state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                if (w_changed && w_ready)
                    w_accept = 1'b1;
                else if (w_changed || !w_onehot)
                    w_state_next = S_TRACK;
            end
            default: w_state_next = S_TRACK;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hex   <= '0;
            r_valid <= '0;
            r_seen  <= '0;
            r_upd   <= 1'b0;
            r_err   <= 1'b0;
            r_frame <= 1'b0;
            r_idx   <= '0;
        end else begin
            r_upd   <= 1'b0;
            r_err   <= 1'b0;
            r_frame <= 1'b0;
            if (w_accept) begin
                r_idx <= w_idx;
                if (w_dec[4]) begin
                    r_hex[w_idx*4 +: 4] <= w_dec[3:0];
                    r_valid[w_idx]      <= 1'b1;
                    r_upd               <= 1'b1;
                end else begin
                    r_valid[w_idx] <= 1'b0;
                    r_err          <= 1'b1;
                end
                if (w_seen_next == C_ALL_SEEN) begin
                    r_frame <= 1'b1;
                    r_seen  <= '0;
                end else begin
                    r_seen <= w_seen_next;
                end
            end
        end
    end

    assign hex_out     = r_hex;
    assign digit_valid = r_valid;
    assign upd_pulse   = r_upd;
    assign err_pulse   = r_err;
    assign upd_idx     = r_idx;
    assign frame_done  = r_frame;

endmodule
`default_nettype wire
